// File: rtl/host_descriptor_arbiter_pkg.sv
// Shared constants, round-robin pointer type and descriptor packing for the
// host descriptor arbiter.
package host_descriptor_arbiter_pkg;

    localparam int unsigned DESC_W     = 22;
    localparam int unsigned BUFID_W    = 9;
    localparam int unsigned TAG_HI     = 47;
    localparam int unsigned TAG_LO     = 36;
    localparam int unsigned TAG_W      = TAG_HI - TAG_LO + 1;
    localparam int unsigned LOOKUP_BIT = 21;

    localparam int unsigned REQ_HCP = 0;
    localparam int unsigned REQ_NET = 1;

    typedef enum logic {
        RrHcp = 1'(REQ_HCP),
        RrNet = 1'(REQ_NET)
    } rr_e;

    // Takes only the tsntag bits that survive into the descriptor.
    function automatic logic [DESC_W-1:0] pack_desc(input logic               flag,
                                                    input logic [TAG_W-1:0]   tag_hi,
                                                    input logic [BUFID_W-1:0] bufid);
        logic [DESC_W-1:0] d;
        d                           = '0;
        d[LOOKUP_BIT]               = flag;
        d[LOOKUP_BIT-1 -: TAG_W]    = tag_hi;
        d[BUFID_W-1:0]              = bufid;
        return d;
    endfunction

endpackage

// File: rtl/host_descriptor_fifo.sv
// Register-array first-word-fall-through FIFO with an explicit occupancy count.
module host_descriptor_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FIFO_AW    = 2,
    parameter int unsigned DESC_W     = 22
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DESC_W-1:0] iv_wdata,
    input  logic              i_ready,
    output logic [DESC_W-1:0] ov_rdata,
    output logic              o_valid,
    output logic [FIFO_AW:0]  ov_count,
    output logic              o_full
);

    localparam int unsigned CntW = FIFO_AW + 1;
    localparam logic [FIFO_AW:0] FullCnt = CntW'(FIFO_DEPTH);

    logic [DESC_W-1:0]  mem_q [FIFO_DEPTH];
    logic [DESC_W-1:0]  mem_d [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               pop;

    // Full/empty come from the count alone; pointers just wrap.
    always_comb begin
        o_valid  = (count_q != '0);
        pop      = o_valid & i_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_push) begin
            mem_d[wr_ptr_q] = iv_wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({i_push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    assign ov_rdata = mem_q[rd_ptr_q];
    assign ov_count = count_q;
    assign o_full   = (count_q == FullCnt);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/host_descriptor_arbiter.sv
// Round-robin arbiter between the HCP and network descriptor requesters, feeding
// a small FWFT FIFO toward the frame inverse-mapping stage.
module host_descriptor_arbiter
    import host_descriptor_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FIFO_AW    = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [47:0]         iv_tsntag_hcp,
    input  logic [8:0]          iv_bufid_hcp,
    input  logic                i_inverse_map_lookup_flag_hcp,
    input  logic                i_descriptor_wr_hcp,
    output logic                o_descriptor_ack_hcp,
    input  logic [47:0]         iv_tsntag_network,
    input  logic [8:0]          iv_bufid_network,
    input  logic                i_inverse_map_lookup_flag_network,
    input  logic                i_descriptor_wr_network,
    output logic                o_descriptor_ack_network,
    output logic [21:0]         ov_descriptor,
    output logic                o_descriptor_wr,
    input  logic                i_descriptor_ready,
    output logic                o_fifo_full,
    output logic [FIFO_AW:0]    ov_fifo_usedw
);

    logic              ack_hcp_q, ack_hcp_d;
    logic              ack_net_q, ack_net_d;
    rr_e               rr_q, rr_d;
    logic              elig_hcp, elig_net;
    logic              accept, grant_hcp;
    logic [DESC_W-1:0] push_desc;
    logic              fifo_full;
    logic              unused_tag_bits;

    assign unused_tag_bits = ^{iv_tsntag_hcp[TAG_LO-1:0], iv_tsntag_network[TAG_LO-1:0]};

    // A requester is masked during its ack cycle, while it is still dropping wr.
    always_comb begin
        elig_hcp  = i_descriptor_wr_hcp & ~ack_hcp_q;
        elig_net  = i_descriptor_wr_network & ~ack_net_q;
        accept    = (elig_hcp | elig_net) & ~fifo_full;
        grant_hcp = elig_hcp & (~elig_net | (rr_q == RrHcp));
        ack_hcp_d = accept & grant_hcp;
        ack_net_d = accept & ~grant_hcp;
        rr_d      = rr_q;
        if (accept && elig_hcp && elig_net) begin
            rr_d = grant_hcp ? RrNet : RrHcp;
        end
        push_desc = grant_hcp
            ? pack_desc(i_inverse_map_lookup_flag_hcp, iv_tsntag_hcp[TAG_HI:TAG_LO],
                        iv_bufid_hcp)
            : pack_desc(i_inverse_map_lookup_flag_network, iv_tsntag_network[TAG_HI:TAG_LO],
                        iv_bufid_network);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ack_hcp_q <= 1'b0;
            ack_net_q <= 1'b0;
            rr_q      <= RrHcp;
        end else begin
            ack_hcp_q <= ack_hcp_d;
            ack_net_q <= ack_net_d;
            rr_q      <= rr_d;
        end
    end

    assign o_descriptor_ack_hcp     = ack_hcp_q;
    assign o_descriptor_ack_network = ack_net_q;
    assign o_fifo_full              = fifo_full;

    host_descriptor_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW),
        .DESC_W     (DESC_W)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_push   (accept),
        .iv_wdata (push_desc),
        .i_ready  (i_descriptor_ready),
        .ov_rdata (ov_descriptor),
        .o_valid  (o_descriptor_wr),
        .ov_count (ov_fifo_usedw),
        .o_full   (fifo_full)
    );

endmodule

// File: tb/tb_host_descriptor_arbiter.sv
// Scoreboard bench for host_descriptor_arbiter: requester agents, output monitor,
// and one task per scenario.
module tb_host_descriptor_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] tag_hcp, tag_net;
    logic [8:0]  bufid_hcp, bufid_net;
    logic        flag_hcp, flag_net;
    logic        wr_hcp, wr_net;
    logic        ack_hcp, ack_net;
    logic [21:0] desc;
    logic        dwr;
    logic        ready;
    logic        full;
    logic [2:0]  usedw;

    typedef struct packed {
        logic        flag;
        logic [47:0] tag;
        logic [8:0]  bufid;
    } req_t;

    req_t        q_hcp[$];
    req_t        q_net[$];
    logic [21:0] sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_out = 0;
    int          acks_hcp = 0;
    int          acks_net = 0;

    always #5 clk = ~clk;

    host_descriptor_arbiter #(
        .FIFO_DEPTH (4),
        .FIFO_AW    (2)
    ) dut (
        .i_clk                             (clk),
        .i_rst                             (rst),
        .iv_tsntag_hcp                     (tag_hcp),
        .iv_bufid_hcp                      (bufid_hcp),
        .i_inverse_map_lookup_flag_hcp     (flag_hcp),
        .i_descriptor_wr_hcp               (wr_hcp),
        .o_descriptor_ack_hcp              (ack_hcp),
        .iv_tsntag_network                 (tag_net),
        .iv_bufid_network                  (bufid_net),
        .i_inverse_map_lookup_flag_network (flag_net),
        .i_descriptor_wr_network           (wr_net),
        .o_descriptor_ack_network          (ack_net),
        .ov_descriptor                     (desc),
        .o_descriptor_wr                   (dwr),
        .i_descriptor_ready                (ready),
        .o_fifo_full                       (full),
        .ov_fifo_usedw                     (usedw)
    );

    function automatic logic [21:0] exp_desc(input req_t r);
        logic [47:0] t;
        t = r.tag;
        return {r.flag, t[47:36], r.bufid};
    endfunction

    function automatic req_t mk_req(input logic f, input logic [47:0] t, input logic [8:0] b);
        req_t r;
        r.flag  = f;
        r.tag   = t;
        r.bufid = b;
        return r;
    endfunction

    // Requesters present the head of their queue and retire it on ack.
    task automatic agent_loop();
        forever begin
            @(negedge clk);
            if (ack_hcp === 1'b1) begin
                acks_hcp++;
                if (q_hcp.size() != 0) void'(q_hcp.pop_front());
            end
            if (ack_net === 1'b1) begin
                acks_net++;
                if (q_net.size() != 0) void'(q_net.pop_front());
            end
            wr_hcp = (q_hcp.size() != 0);
            if (q_hcp.size() != 0) begin
                tag_hcp = q_hcp[0].tag; bufid_hcp = q_hcp[0].bufid; flag_hcp = q_hcp[0].flag;
            end
            wr_net = (q_net.size() != 0);
            if (q_net.size() != 0) begin
                tag_net = q_net[0].tag; bufid_net = q_net[0].bufid; flag_net = q_net[0].flag;
            end
        end
    endtask

    task automatic monitor_loop();
        logic [21:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && dwr === 1'b1 && ready === 1'b1) begin
                n_checks++;
                n_out++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_unexpected: got %h, required no output", desc);
                end else begin
                    e = sb.pop_front();
                    if (desc !== e) begin
                        n_fail++;
                        $display("FAIL out_order: got %h, required %h", desc, e);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        q_hcp.delete();
        q_net.delete();
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk);
            #1;
            if (q_hcp.size() == 0 && q_net.size() == 0 && sb.size() == 0 &&
                usedw == 3'd0 && dwr == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if ({ack_hcp, ack_net, dwr, full} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 0000", {ack_hcp, ack_net, dwr, full});
        end
        n_checks++;
        if (usedw !== 3'd0) begin
            n_fail++; $display("FAIL reset_usedw: got %0d, required 0", usedw);
        end
        n_checks++;
        if (desc !== 22'h0) begin
            n_fail++; $display("FAIL reset_desc: got %h, required 000000", desc);
        end
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        @(posedge clk);
        #1;
        ready = 1'b1;
        q_hcp.push_back(mk_req(1'b1, 48'hABC0_0000_0000, 9'h05));
        sb.push_back(22'h357805);
        @(posedge clk);
        #1;
        n_checks++;
        if ({ack_hcp, ack_net} !== 2'b10) begin
            n_fail++; $display("FAIL single_ack: got %b, required 10", {ack_hcp, ack_net});
        end
        n_checks++;
        if (dwr !== 1'b1 || desc !== 22'h357805) begin
            n_fail++; $display("FAIL single_out: got wr=%b %h, required wr=1 357805", dwr, desc);
        end
        n_checks++;
        if (usedw !== 3'd1) begin
            n_fail++; $display("FAIL single_usedw: got %0d, required 1", usedw);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({ack_hcp, dwr} !== 2'b00 || usedw !== 3'd0) begin
            n_fail++;
            $display("FAIL single_after: got ack=%b wr=%b usedw=%0d, required 0 0 0",
                     ack_hcp, dwr, usedw);
        end
        wait_idle(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL single_idle: got busy, required idle");
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        int a_h, a_n;
        req_t h0, h1, n0, n1;
        do_reset();
        ready = 1'b1;
        a_h = acks_hcp;
        a_n = acks_net;
        h0 = mk_req(1'b0, 48'h1110_0000_0000, 9'h011);
        h1 = mk_req(1'b1, 48'h2220_0000_0000, 9'h022);
        n0 = mk_req(1'b1, 48'h3330_0000_0000, 9'h133);
        n1 = mk_req(1'b0, 48'h4440_0000_0000, 9'h144);
        q_hcp.push_back(h0); q_hcp.push_back(h1);
        q_net.push_back(n0); q_net.push_back(n1);
        sb.push_back(exp_desc(h0)); sb.push_back(exp_desc(n0));
        sb.push_back(exp_desc(h1)); sb.push_back(exp_desc(n1));
        @(posedge clk);
        #1;
        n_checks++;
        if ({ack_hcp, ack_net} !== 2'b10) begin
            n_fail++; $display("FAIL sim_first_ack: got %b, required 10", {ack_hcp, ack_net});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({ack_hcp, ack_net} !== 2'b01) begin
            n_fail++; $display("FAIL sim_second_ack: got %b, required 01", {ack_hcp, ack_net});
        end
        wait_idle(40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL sim_idle: got busy, required idle");
        end
        n_checks++;
        if (acks_hcp - a_h != 2 || acks_net - a_n != 2) begin
            n_fail++;
            $display("FAIL sim_ack_count: got %0d/%0d, required 2/2", acks_hcp - a_h,
                     acks_net - a_n);
        end
    endtask

    // Fills the FIFO under backpressure, then checks the pop cycle does not free a slot.
    task automatic test_backpressure();
        bit ok;
        int a_h, a_n;
        req_t h[3];
        req_t n[3];
        do_reset();
        ready = 1'b0;
        a_h = acks_hcp;
        a_n = acks_net;
        for (int i = 0; i < 3; i++) begin
            h[i] = mk_req(i[0], {12'h500 + 12'(i), 36'h0}, 9'(8'h20 + i));
            n[i] = mk_req(~i[0], {12'h600 + 12'(i), 36'h0}, 9'(8'h40 + i));
            q_hcp.push_back(h[i]);
            q_net.push_back(n[i]);
        end
        sb.push_back(exp_desc(h[0])); sb.push_back(exp_desc(n[0]));
        sb.push_back(exp_desc(h[1])); sb.push_back(exp_desc(n[1]));
        sb.push_back(exp_desc(n[2])); sb.push_back(exp_desc(h[2]));
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (acks_hcp - a_h != 2 || acks_net - a_n != 2) begin
            n_fail++;
            $display("FAIL bp_ack_count: got %0d/%0d, required 2/2", acks_hcp - a_h,
                     acks_net - a_n);
        end
        n_checks++;
        if (full !== 1'b1 || usedw !== 3'd4) begin
            n_fail++; $display("FAIL bp_full: got full=%b usedw=%0d, required 1 4", full, usedw);
        end
        n_checks++;
        if ({ack_hcp, ack_net} !== 2'b00) begin
            n_fail++; $display("FAIL bp_stall_ack: got %b, required 00", {ack_hcp, ack_net});
        end
        ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (usedw !== 3'd3 || {ack_hcp, ack_net} !== 2'b00) begin
            n_fail++;
            $display("FAIL full_pop_cycle: got usedw=%0d ack=%b, required 3 00", usedw,
                     {ack_hcp, ack_net});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (usedw !== 3'd3 || {ack_hcp, ack_net} !== 2'b01) begin
            n_fail++;
            $display("FAIL full_next_accept: got usedw=%0d ack=%b, required 3 01", usedw,
                     {ack_hcp, ack_net});
        end
        wait_idle(40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL bp_idle: got busy, required idle");
        end
        n_checks++;
        if (acks_hcp - a_h != 3 || acks_net - a_n != 3) begin
            n_fail++;
            $display("FAIL bp_ack_total: got %0d/%0d, required 3/3", acks_hcp - a_h,
                     acks_net - a_n);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        req_t ha, na;
        do_reset();
        ready = 1'b0;
        q_hcp.push_back(mk_req(1'b1, 48'h7770_0000_0000, 9'h070));
        q_hcp.push_back(mk_req(1'b0, 48'h7780_0000_0000, 9'h071));
        q_net.push_back(mk_req(1'b1, 48'h7790_0000_0000, 9'h072));
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (usedw !== 3'd3) begin
            n_fail++; $display("FAIL rstmid_pre_usedw: got %0d, required 3", usedw);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({dwr, ack_hcp, ack_net, full} !== 4'b0000 || usedw !== 3'd0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got flags=%b usedw=%0d, required 0000 0",
                     {dwr, ack_hcp, ack_net, full}, usedw);
        end
        q_hcp.delete();
        q_net.delete();
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        ready = 1'b1;
        ha = mk_req(1'b0, 48'h8880_0000_0000, 9'h0AA);
        na = mk_req(1'b1, 48'h9990_0000_0000, 9'h1BB);
        q_hcp.push_back(ha);
        q_net.push_back(na);
        sb.push_back(exp_desc(ha));
        sb.push_back(exp_desc(na));
        @(posedge clk);
        #1;
        n_checks++;
        if ({ack_hcp, ack_net} !== 2'b10) begin
            n_fail++; $display("FAIL rstmid_rr: got %b, required 10", {ack_hcp, ack_net});
        end
        n_checks++;
        if (dwr !== 1'b1 || desc !== exp_desc(ha)) begin
            n_fail++;
            $display("FAIL rstmid_first_out: got wr=%b %h, required wr=1 %h", dwr, desc,
                     exp_desc(ha));
        end
        wait_idle(30, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL rstmid_idle: got busy, required idle");
        end
    endtask

    task automatic test_wraparound();
        bit ok;
        int o0;
        req_t r;
        @(posedge clk);
        #1;
        o0 = n_out;
        for (int i = 0; i < 10; i++) begin
            r = mk_req(i[0], {12'($urandom), 36'($urandom)}, 9'(i));
            q_hcp.push_back(r);
            sb.push_back(exp_desc(r));
        end
        repeat (50) begin
            @(posedge clk);
            #1 ready = 1'($urandom_range(0, 1));
        end
        ready = 1'b1;
        wait_idle(100, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL wrap_idle: got busy, required idle");
        end
        n_checks++;
        if (n_out - o0 != 10) begin
            n_fail++; $display("FAIL wrap_count: got %0d, required 10", n_out - o0);
        end
    endtask

    initial begin
        rst = 1'b1;
        ready = 1'b0;
        wr_hcp = 1'b0; wr_net = 1'b0;
        tag_hcp = '0; tag_net = '0;
        bufid_hcp = '0; bufid_net = '0;
        flag_hcp = 1'b0; flag_net = 1'b0;
        fork
            agent_loop();
            monitor_loop();
        join_none
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_reset_mid();
        test_wraparound();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/host_descriptor_arbiter.md
Name: host_descriptor_arbiter

Overview:
- Shares the single descriptor input of the host transmit path between two requesters: the HCP port and the network port.
- Each requester presents a 48-bit tsntag, a 9-bit bufid and an inverse-map lookup flag under a wr/ack handshake.
- The arbiter grants in round-robin order, packs each accepted request into a 22-bit descriptor, and buffers it in a small FIFO.
- It drains the FIFO to the frame inverse-mapping stage under a wr/ready handshake.

Parameters:
- FIFO_DEPTH, 4, number of buffered descriptors; power of two, minimum 2.
- FIFO_AW, 2, log2(FIFO_DEPTH), pointer width.

Ports:
- i_clk  in  1  single clock for the whole block.
- i_rst  in  1  reset, asynchronous, active-high.
- iv_tsntag_hcp  in  48  HCP tsntag.
- iv_bufid_hcp  in  9  HCP buffer id.
- i_inverse_map_lookup_flag_hcp  in  1  HCP lookup flag.
- i_descriptor_wr_hcp  in  1  HCP request; held until ack.
- o_descriptor_ack_hcp  out  1  one-cycle HCP accept pulse.
- iv_tsntag_network  in  48  network tsntag.
- iv_bufid_network  in  9  network buffer id.
- i_inverse_map_lookup_flag_network  in  1  network lookup flag.
- i_descriptor_wr_network  in  1  network request; held until ack.
- o_descriptor_ack_network  out  1  one-cycle network accept pulse.
- ov_descriptor  out  22  packed as {lookup_flag, tsntag[47:36], bufid}.
- o_descriptor_wr  out  1  descriptor valid.
- i_descriptor_ready  in  1  downstream can accept.
- o_fifo_full  out  1  status: FIFO full.
- ov_fifo_usedw  out  FIFO_AW+1  status: FIFO occupancy.

Behaviour:
- Reset (async, i_rst=1):
  - Both acks, o_descriptor_wr, o_fifo_full and ov_fifo_usedw go to 0; ov_descriptor goes to 0.
  - FIFO pointers go to 0 and the round-robin pointer goes to HCP (HCP wins the first tie).
  - Reset asserted mid-operation drops all buffered descriptors. A requester still holding wr after reset release is re-arbitrated normally.
- Request eligibility:
  - A requester is eligible when its wr=1 and its ack is not currently high.
  - This masking prevents double-accept during the ack cycle, in which the requester is still dropping wr.
- Accept condition:
  - At least one requester is eligible and registered count < FIFO_DEPTH.
  - The full check uses registered count only; a pop in the same cycle does not free a slot for the push.
- Arbitration:
  - If exactly one requester is eligible, it wins.
  - If both are eligible, the requester selected by the round-robin pointer wins, and the pointer then moves to the other requester.
  - The pointer changes only when both requesters are eligible.
- Accept cycle t:
  - The winner's packed descriptor is written to the FIFO at the write pointer.
  - The write pointer increments modulo FIFO_DEPTH.
  - The winner's ack is 1 during cycle t+1 for exactly one cycle.
  - Accept-to-ack latency is 1 cycle; the loser keeps wr held and its ack stays 0.
- Output (first-word-fall-through):
  - o_descriptor_wr = (count != 0); ov_descriptor = fifo[rd_ptr].
  - A transfer occurs when o_descriptor_wr and i_descriptor_ready are both 1 on a clock edge. On a transfer, rd_ptr increments modulo FIFO_DEPTH.
  - ov_descriptor and o_descriptor_wr stay stable while ready=0.
  - Minimum latency from accept edge to o_descriptor_wr=1 is 1 cycle, i.e. the same cycle the ack pulses.
- Count update:
  - count increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
  - ov_fifo_usedw = count; o_fifo_full = (count == FIFO_DEPTH).
- Pointers wrap naturally at FIFO_DEPTH; no pointer equality is used to derive full or empty.
- Empty FIFO with ready=1: no pop, o_descriptor_wr stays 0.
- Full FIFO: no accepts; requesters stall with wr held.
- Throughput: at most 1 accept per cycle. A single requester can be accepted at most every 2 cycles, because of the ack mask. Two requesters interleave for 1 accept per cycle.

Decomposition:
- Shared package holds:
  - Descriptor field constants: DESC_W=22, BUFID_W=9, TAG_HI=47, TAG_LO=36, LOOKUP_BIT=21.
  - Requester index constants: REQ_HCP=0, REQ_NET=1.
  - A pack function from (flag, tsntag, bufid) to the 22-bit descriptor.
- One natural sub-module: host_descriptor_fifo, a register-array FWFT FIFO with count, parameterised by FIFO_DEPTH and DESC_W. The arbiter FSM, round-robin pointer and ack logic stay in the top.

Test Plan:
- Single request:
  - Stimulus: HCP wr with tsntag=48'hABC0_0000_0000, bufid=9'h05, flag=1, ready=1.
  - Response: ack_hcp pulses 1 cycle after the accept edge; o_descriptor_wr=1 with ov_descriptor={1'b1,12'hABC,9'h05}=22'h357805; popped the next cycle; usedw returns to 0.
- Simultaneous requests after reset:
  - Stimulus: both wr held, ready=1.
  - Response: HCP accepted first, network next cycle, then alternating. Output order is HCP, NET, HCP, NET; each ack appears exactly once per request.
- Backpressure:
  - Stimulus: ready=0, 6 back-to-back alternating requests.
  - Response: exactly 4 acks; o_fifo_full=1; usedw=4; the remaining 2 requesters stall with ack=0.
  - Then ready=1: descriptors drain in accept order and the stalled requests are accepted afterwards.
- Full plus simultaneous pop:
  - Stimulus: count=4, ready=1, new request pending.
  - Response: no accept in the pop cycle (usedw goes 4 to 3); accept in the following cycle.
- Reset mid-operation:
  - Stimulus: usedw=3, assert i_rst asynchronously between edges.
  - Response: o_descriptor_wr, acks and usedw go to 0 immediately. After release the RR pointer is HCP, and the first output is the first post-reset accept.
- Wrap-around:
  - Stimulus: 10 requests with bufid 0..9 through FIFO_DEPTH=4 under random ready.
  - Response: output bufids arrive as 0..9 in order with none lost or duplicated.
